// File: rtl/fetch_seq_pkg.sv
// Shared constants for the instruction fetch sequencer: reset vector,
// FSM encoding and stall-bus bit positions.
package fetch_seq_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    // Stall bus bit positions, one per pipeline stage.
    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;
    localparam int STALL_W   = 6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_npc.sv
// Next fetch address selection: flush > pending redirect > live branch > pc+4.
module fetch_npc
    import fetch_seq_pkg::*;
(
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        redir_vld_i,
    input  logic [31:0] redir_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o
);

    always_comb begin
        if (flush_i)          npc_o = flush_pc_i;
        else if (redir_vld_i) npc_o = redir_pc_i;
        else if (branch_i)    npc_o = branch_target_i;
        else                  npc_o = pc_i + 32'd4;
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding request on the inst bus,
// a one-entry hold buffer for IF stalls, and a drain state that swallows
// the in-flight fetch after a flush.
module fetch_seq
    import fetch_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_i,
    input  logic                flush_i,
    input  logic [31:0]         flush_pc_i,
    input  logic [STALL_W-1:0]  stall_i,
    output logic                inst_req_o,
    output logic [31:0]         inst_addr_o,
    input  logic                inst_ack_i,
    input  logic [31:0]         inst_rdata_i,
    output logic                inst_valid_o,
    output logic [31:0]         inst_o,
    output logic [31:0]         inst_pc_o,
    output logic                stall_req_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  redir_q, redir_d;
    logic         redir_vld_q, redir_vld_d;
    logic [31:0]  buf_inst_q, buf_inst_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  npc;
    logic         stall_if;
    logic         unused_stall;

    assign stall_if     = stall_i[STALL_IF];
    assign unused_stall = ^stall_i;

    // Live branches only steer the address from RUN; in DRAIN the redirect
    // register already carries the flush target and always outranks them.
    fetch_npc u_npc (
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .redir_vld_i     (redir_vld_q),
        .redir_pc_i      (redir_q),
        .branch_i        (branch_flag_i && (state_q == ST_RUN)),
        .branch_target_i (branch_target_i),
        .pc_i            (fetch_addr_q),
        .npc_o           (npc)
    );

    assign inst_req_o   = (state_q != ST_HOLD);
    assign inst_addr_o  = fetch_addr_q;
    assign stall_req_o  = ((state_q == ST_RUN) && !inst_ack_i) || (state_q == ST_DRAIN);
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        redir_d      = redir_q;
        redir_vld_d  = redir_vld_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        valid_d      = 1'b0;
        inst_d       = inst_q;
        pc_d         = pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    redir_vld_d = 1'b0;
                    if (inst_ack_i) begin
                        fetch_addr_d = npc;
                    end else begin
                        redir_d     = flush_pc_i;
                        redir_vld_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end else if (inst_ack_i) begin
                    fetch_addr_d = npc;
                    redir_vld_d  = 1'b0;
                    if (stall_if) begin
                        buf_inst_d = inst_rdata_i;
                        buf_pc_d   = fetch_addr_q;
                        state_d    = ST_HOLD;
                    end else begin
                        valid_d = 1'b1;
                        inst_d  = inst_rdata_i;
                        pc_d    = fetch_addr_q;
                    end
                end else if (branch_flag_i) begin
                    redir_d     = branch_target_i;
                    redir_vld_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    fetch_addr_d = npc;
                    redir_vld_d  = 1'b0;
                    state_d      = ST_RUN;
                end else begin
                    if (branch_flag_i) begin
                        redir_d     = branch_target_i;
                        redir_vld_d = 1'b1;
                    end
                    if (!stall_if) begin
                        valid_d = 1'b1;
                        inst_d  = buf_inst_q;
                        pc_d    = buf_pc_q;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inst_ack_i) begin
                    fetch_addr_d = npc;
                    redir_vld_d  = 1'b0;
                    state_d      = ST_RUN;
                end else if (flush_i) begin
                    redir_d = flush_pc_i;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            fetch_addr_q <= RESET_PC;
            redir_q      <= '0;
            redir_vld_q  <= 1'b0;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
            valid_q      <= 1'b0;
            inst_q       <= '0;
            pc_q         <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            redir_q      <= redir_d;
            redir_vld_q  <= redir_vld_d;
            buf_inst_q   <= buf_inst_d;
            buf_pc_q     <= buf_pc_d;
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed cycle table, reset-in-drain sequence, then
// random traffic against a queue-based model of the fetch stream.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [5:0]  stall_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        stall_req_o;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign inst_rdata_i = memf(inst_addr_o);

    fetch_seq dut (
        .clk             (clk),
        .rst             (rst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .stall_i         (stall_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_ack_i      (inst_ack_i),
        .inst_rdata_i    (inst_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .stall_req_o     (stall_req_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h @%0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        ack, flush, br, stall;
        logic [31:0] arg;
        logic        e_req, e_streq, e_valid;
        logic [31:0] e_addr, e_pc;
    } vec_t;

    function automatic vec_t mk(input logic ack, flush, br, stall, input logic [31:0] arg,
                                input logic e_req, e_streq, e_valid,
                                input logic [31:0] e_addr, e_pc);
        vec_t v;
        v.ack = ack; v.flush = flush; v.br = br; v.stall = stall; v.arg = arg;
        v.e_req = e_req; v.e_streq = e_streq; v.e_valid = e_valid;
        v.e_addr = e_addr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive(input logic ack, flush, br, input logic [5:0] stall,
                         input logic [31:0] tgt, input logic [31:0] fpc);
        inst_ack_i      = ack;
        flush_i         = flush;
        branch_flag_i   = br;
        stall_i         = stall;
        branch_target_i = tgt;
        flush_pc_i      = fpc;
    endtask

    // Reference model state: address of the current/next fetch, pending
    // redirect, held instructions (by pc), and whether the in-flight fetch
    // is doomed by a flush.
    logic [31:0] m_addr, m_redir, e_pc, e_inst, nxt;
    logic        m_redir_v, m_discard, e_valid, req_e;
    logic [31:0] hold_q[$];

    vec_t tbl[30];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);

        // ack, flush, br, stall, arg | req, stall_req, valid, addr, pc
        tbl[0]  = mk(1,0,0,0,0,           1,0,0, 32'hBFC0_0000, 32'h0);
        tbl[1]  = mk(1,0,0,0,0,           1,0,1, 32'hBFC0_0004, 32'hBFC0_0000);
        tbl[2]  = mk(1,0,0,0,0,           1,0,1, 32'hBFC0_0008, 32'hBFC0_0004);
        tbl[3]  = mk(0,0,0,0,0,           1,1,1, 32'hBFC0_000C, 32'hBFC0_0008);
        tbl[4]  = mk(0,0,0,0,0,           1,1,0, 32'hBFC0_000C, 32'hBFC0_0008);
        tbl[5]  = mk(1,0,0,0,0,           1,0,0, 32'hBFC0_000C, 32'hBFC0_0008);
        tbl[6]  = mk(0,0,1,0,32'h8000_1000, 1,1,1, 32'hBFC0_0010, 32'hBFC0_000C);
        tbl[7]  = mk(1,0,0,0,0,           1,0,0, 32'hBFC0_0010, 32'hBFC0_000C);
        tbl[8]  = mk(1,0,0,0,0,           1,0,1, 32'h8000_1000, 32'hBFC0_0010);
        tbl[9]  = mk(1,0,0,1,0,           1,0,1, 32'h8000_1004, 32'h8000_1000);
        tbl[10] = mk(1,0,0,1,0,           0,0,0, 32'h8000_1008, 32'h8000_1000);
        tbl[11] = mk(0,0,0,1,0,           0,0,0, 32'h8000_1008, 32'h8000_1000);
        tbl[12] = mk(1,0,0,1,0,           0,0,0, 32'h8000_1008, 32'h8000_1000);
        tbl[13] = mk(0,0,0,0,0,           0,0,0, 32'h8000_1008, 32'h8000_1000);
        tbl[14] = mk(0,0,0,0,0,           1,1,1, 32'h8000_1008, 32'h8000_1004);
        tbl[15] = mk(0,1,0,0,32'hBFC0_0380, 1,1,0, 32'h8000_1008, 32'h8000_1004);
        tbl[16] = mk(0,0,0,0,0,           1,1,0, 32'h8000_1008, 32'h8000_1004);
        tbl[17] = mk(1,0,0,0,0,           1,1,0, 32'h8000_1008, 32'h8000_1004);
        tbl[18] = mk(1,0,0,0,0,           1,0,0, 32'hBFC0_0380, 32'h8000_1004);
        tbl[19] = mk(0,0,0,0,0,           1,1,1, 32'hBFC0_0384, 32'hBFC0_0380);
        tbl[20] = mk(1,0,1,0,32'hFFFF_FFFC, 1,0,0, 32'hBFC0_0384, 32'hBFC0_0380);
        tbl[21] = mk(1,0,0,0,0,           1,0,1, 32'hFFFF_FFFC, 32'hBFC0_0384);
        tbl[22] = mk(0,0,0,0,0,           1,1,1, 32'h0000_0000, 32'hFFFF_FFFC);
        tbl[23] = mk(1,0,0,1,0,           1,0,0, 32'h0000_0000, 32'hFFFF_FFFC);
        tbl[24] = mk(0,1,1,1,32'hBFC0_0380, 0,0,0, 32'h0000_0004, 32'hFFFF_FFFC);
        tbl[25] = mk(0,0,0,0,0,           1,1,0, 32'hBFC0_0380, 32'hFFFF_FFFC);
        tbl[26] = mk(1,0,0,0,0,           1,0,0, 32'hBFC0_0380, 32'hFFFF_FFFC);
        tbl[27] = mk(0,0,0,0,0,           1,1,1, 32'hBFC0_0384, 32'hBFC0_0380);
        tbl[28] = mk(1,1,0,0,32'h0000_1000, 1,0,0, 32'hBFC0_0384, 32'hBFC0_0380);
        tbl[29] = mk(0,0,0,0,0,           1,1,0, 32'h0000_1000, 32'hBFC0_0380);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_inst", inst_o, 32'h0);

        for (int i = 0; i < 30; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].ack, tbl[i].flush, tbl[i].br, {5'd0, tbl[i].stall}, tbl[i].arg, tbl[i].arg);
            #1;
            chk($sformatf("t%0d_req", i),   {31'd0, inst_req_o},   {31'd0, tbl[i].e_req});
            chk($sformatf("t%0d_addr", i),  inst_addr_o,           tbl[i].e_addr);
            chk($sformatf("t%0d_streq", i), {31'd0, stall_req_o},  {31'd0, tbl[i].e_streq});
            chk($sformatf("t%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("t%0d_pc", i),    inst_pc_o,             tbl[i].e_pc);
            if (tbl[i].e_valid) chk($sformatf("t%0d_inst", i), inst_o, memf(tbl[i].e_pc));
        end

        // Reset while draining with a latched flush target.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 6'd0, 32'd0, 32'hBFC0_0380);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 6'd0, 32'h1234_5678, 32'd0);
        #1;
        chk("drain_streq", {31'd0, stall_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        #1;
        chk("rst_drain_req",   {31'd0, inst_req_o},   32'd1);
        chk("rst_drain_addr",  inst_addr_o,           32'hBFC0_0000);
        chk("rst_drain_valid", {31'd0, inst_valid_o}, 32'd0);

        // Random phase starting from the post-reset state.
        m_addr = 32'hBFC0_0000; m_redir = '0; m_redir_v = 1'b0; m_discard = 1'b0;
        e_valid = 1'b0; e_pc = '0; e_inst = '0;
        hold_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic        a, f, b;
            logic [5:0]  s;
            logic [31:0] t, fp;
            a  = ($urandom_range(0, 1) == 0);
            f  = ($urandom_range(0, 15) == 0);
            b  = ($urandom_range(0, 5) == 0);
            s  = 6'($urandom);
            s[0] = ($urandom_range(0, 2) == 0);
            t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 0;
            t[1:0] = 2'b00;
            fp = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0380 : {$urandom} & 32'hFFFF_FFFC;
            if (c == 0) begin
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            drive(a, f, b, s, t, fp);
            #1;
            req_e = (hold_q.size() == 0);
            chk("rnd_req",   {31'd0, inst_req_o},   {31'd0, req_e});
            chk("rnd_addr",  inst_addr_o,           m_addr);
            chk("rnd_streq", {31'd0, stall_req_o},  {31'd0, m_discard || (req_e && !a)});
            chk("rnd_valid", {31'd0, inst_valid_o}, {31'd0, e_valid});
            chk("rnd_pc",    inst_pc_o,             e_pc);
            chk("rnd_inst",  inst_o,                e_inst);

            e_valid = 1'b0;
            if (req_e && a) begin
                if (!m_discard && !f) begin
                    if (s[0]) hold_q.push_back(m_addr);
                    else begin e_valid = 1'b1; e_pc = m_addr; e_inst = memf(m_addr); end
                end
                nxt = f ? fp : m_redir_v ? m_redir : b ? t : m_addr + 32'd4;
                m_addr = nxt; m_redir_v = 1'b0; m_discard = 1'b0;
            end else if (req_e) begin
                if (f) begin m_redir = fp; m_redir_v = 1'b1; m_discard = 1'b1; end
                else if (b && !m_discard) begin m_redir = t; m_redir_v = 1'b1; end
            end else begin
                if (f) begin
                    hold_q.delete(); m_redir_v = 1'b0; m_addr = fp;
                end else begin
                    if (b) begin m_redir = t; m_redir_v = 1'b1; end
                    if (!s[0]) begin
                        e_valid = 1'b1; e_pc = hold_q.pop_front(); e_inst = memf(e_pc);
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: branch_flag_i  in  1  branch taken, decided in ID; applies after the delay-slot fetch.
REQ-004 SHALL have port: branch_target_i  in  32  branch destination.
REQ-005 SHALL have port: flush_i  in  1  exception/eret flush.
REQ-006 SHALL have port: flush_pc_i  in  32  flush destination.
REQ-007 SHALL have port: stall_i  in  6  pipeline stall bus; bit 0 = IF stage stalled.
REQ-008 SHALL have ports: inst_req_o out 1, inst_addr_o out 32, inst_ack_i in 1, inst_rdata_i in 32: instruction memory request/ack bus.
REQ-009 SHALL have ports: inst_valid_o out 1, inst_o out 32, inst_pc_o out 32: instruction delivered to IF/ID.
REQ-010 SHALL have port: stall_req_o  out 1  requests pipeline stall while a fetch is outstanding.
REQ-011 SHALL use constant RESET_PC, default 32'hBFC0_0000: first fetch address.

Function
REQ-012 SHALL implement states RUN, HOLD, DRAIN; reset state RUN.
REQ-013 Bus rule: inst_req_o = 1 in RUN and DRAIN, 0 in HOLD; inst_addr_o = fetch_addr register, stable while inst_req_o = 1 and inst_ack_i = 0; at most one fetch outstanding.
REQ-014 inst_ack_i may arrive the same cycle as req (zero wait) or any later cycle; ack sampled only while inst_req_o = 1.
REQ-015 RUN, ack, no flush, stall_i[0] = 0: next cycle inst_valid_o = 1, inst_o = inst_rdata_i, inst_pc_o = fetch_addr; fetch_addr <= next address per REQ-018.
REQ-016 RUN, ack, no flush, stall_i[0] = 1: capture rdata/addr in hold buffer, go HOLD; fetch_addr <= next address.
REQ-017 HOLD, stall_i[0] = 0, no flush: deliver buffer (inst_valid_o = 1 next cycle), go RUN.
REQ-018 Next address priority: flush target > pending redirect > branch_flag_i that cycle > fetch_addr + 4 (32-bit wrap at 32'hFFFF_FFFC -> 0).
REQ-019 branch_flag_i while a fetch is outstanding without ack, or in HOLD: store branch_target_i in pending-redirect register; consumed by next address computation, then cleared.
REQ-020 flush_i in RUN with ack same cycle: discard data, inst_valid_o = 0 next cycle, fetch_addr <= flush_pc_i, stay RUN.
REQ-021 flush_i in RUN without ack: latch flush_pc_i into redirect (flush priority), go DRAIN; address unchanged.
REQ-022 DRAIN: on ack discard data, fetch_addr <= latched flush target, go RUN; further flush_i in DRAIN overwrites the latched target.
REQ-023 flush_i in HOLD: drop buffer and pending branch redirect, fetch_addr <= flush_pc_i, go RUN.
REQ-024 flush_i SHALL clear any pending branch redirect; inst_valid_o = 0 in the cycle after any flush.
REQ-025 inst_valid_o SHALL be a registered one-cycle pulse per delivered instruction; inst_o/inst_pc_o hold last values otherwise.
REQ-026 stall_req_o = (RUN and inst_req_o and not inst_ack_i) or DRAIN; combinational.

Reset
REQ-027 On rst: state RUN, fetch_addr = RESET_PC, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, redirect cleared, hold buffer cleared.
REQ-028 rst mid-fetch SHALL abandon the outstanding request; the memory ignores ack state across reset; the first post-reset request addresses RESET_PC.

Structure
REQ-029 RESET_PC, state encoding and stall-bus bit indices SHALL live in the shared defines file.
REQ-030 Next-address selection SHALL be one combinational sub-module, fetch_npc.

Verification
REQ-031 Zero-wait ack every cycle, no stalls -> inst_pc_o sequence BFC00000, BFC00004, BFC00008 on consecutive cycles, inst_valid_o held 1.
REQ-032 3-cycle ack latency -> stall_req_o = 1 for 2 cycles, addr stable, one valid pulse per fetch.
REQ-033 Branch to 0x80001000 during an outstanding delay-slot fetch -> delay slot delivered, next inst_pc_o = 0x80001000.
REQ-034 stall_i[0] = 1 at ack for 4 cycles -> HOLD, req = 0, instruction delivered once after stall release, none lost or duplicated.
REQ-035 flush_i with flush_pc_i = 0xBFC00380 while fetch outstanding -> DRAIN, stale data not delivered, next valid inst_pc_o = 0xBFC00380.
REQ-036 rst asserted in DRAIN with pending redirect -> next request addr = BFC00000, inst_valid_o = 0.
